// File: rtl/control_fsm_pkg.sv
// rtl/control_fsm_pkg.sv - shared state, opcode and mux-select encodings for the multicycle control FSM
package control_fsm_pkg;

    // Controller states
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR_PC  = 4'd12,
        S_UPPER    = 4'd13
    } state_t;

    // Supported opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Immediate formats understood by the sign extender
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Result mux select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_RDATA     = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/control_fsm_imm_src_decoder.sv
// rtl/control_fsm_imm_src_decoder.sv - opcode to immediate format and legality decode
module imm_src_decoder
    import control_fsm_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] imm_src,
    output logic       legal
);

    // Pure opcode decode; unknown opcodes fall back to the I format and flag illegal
    always_comb begin
        imm_src = IMM_I;
        legal   = 1'b1;
        unique case (op)
            OP_LOAD, OP_ITYPE, OP_JALR: imm_src = IMM_I;
            OP_STORE:                   imm_src = IMM_S;
            OP_BRANCH:                  imm_src = IMM_B;
            OP_JAL:                     imm_src = IMM_J;
            OP_LUI, OP_AUIPC:           imm_src = IMM_U;
            OP_RTYPE:                   imm_src = IMM_I;
            default: begin
                imm_src = IMM_I;
                legal   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multicycle RV32I-subset control unit
module control_fsm
    import control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       illegal
);

    state_t state_q, state_d;
    logic   legal;

    logic       pc_write_c, ir_write_c, adr_src_c, mem_write_c, reg_write_c, illegal_c;
    logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, alu_op_c;

    // Only funct3[0] distinguishes beq from bne; the other bits are not needed here
    logic unused_funct3;
    assign unused_funct3 = ^funct3[2:1];

    imm_src_decoder u_imm_src_decoder (
        .op      (op),
        .imm_src (imm_src),
        .legal   (legal)
    );

    // State register; reset parks the machine in FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control decode; everything not driven by a state stays 0
    always_comb begin
        state_d      = state_q;
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        adr_src_c    = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        illegal_c    = 1'b0;
        result_src_c = RES_ALUOUT;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_RS2;
        alu_op_c     = ALUOP_ADD;

        unique case (state_q)
            S_FETCH: begin
                alu_src_a_c = SRCA_PC;
                alu_src_b_c = SRCB_FOUR;
                alu_op_c    = ALUOP_ADD;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute old_pc + imm so branch/jal targets sit in alu_out
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
                alu_op_c    = ALUOP_ADD;
                unique case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UPPER;
                    default:           state_d = S_FETCH;
                endcase
                illegal_c = ~legal;
            end
            S_MEMADR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                alu_op_c    = ALUOP_ADD;
                state_d     = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src_c    = 1'b1;
                result_src_c = RES_ALUOUT;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src_c = RES_RDATA;
                reg_write_c  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_c    = 1'b1;
                result_src_c = RES_ALUOUT;
                mem_write_c  = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_RS2;
                alu_op_c    = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                alu_op_c    = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                result_src_c = RES_ALUOUT;
                reg_write_c  = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                // Compare by subtraction; bne inverts the sense via funct3[0]
                alu_src_a_c  = SRCA_RS1;
                alu_src_b_c  = SRCB_RS2;
                alu_op_c     = ALUOP_SUB;
                result_src_c = RES_ALUOUT;
                pc_write_c   = zero ^ funct3[0];
                state_d      = S_FETCH;
            end
            S_JAL, S_JALR_PC: begin
                // Load the target from alu_out while forming the link value old_pc + 4
                pc_write_c   = 1'b1;
                result_src_c = RES_ALUOUT;
                alu_src_a_c  = SRCA_OLDPC;
                alu_src_b_c  = SRCB_FOUR;
                alu_op_c     = ALUOP_ADD;
                state_d      = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                alu_op_c    = ALUOP_ADD;
                state_d     = S_JALR_PC;
            end
            S_UPPER: begin
                alu_src_a_c = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
                alu_op_c    = ALUOP_ADD;
                state_d     = S_ALUWB;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Outputs are forced low while reset is held so an aborted access drops its strobe at once
    always_comb begin
        pc_write   = rst_n & pc_write_c;
        ir_write   = rst_n & ir_write_c;
        adr_src    = rst_n & adr_src_c;
        mem_write  = rst_n & mem_write_c;
        reg_write  = rst_n & reg_write_c;
        illegal    = rst_n & illegal_c;
        result_src = rst_n ? result_src_c : 2'b00;
        alu_src_a  = rst_n ? alu_src_a_c  : 2'b00;
        alu_src_b  = rst_n ? alu_src_b_c  : 2'b00;
        alu_op     = rst_n ? alu_op_c     : 2'b00;
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 op  input  7  instruction opcode, instr[6:0], from the instruction register.
REQ-005 funct3  input  3  instr[14:12].
REQ-006 zero  input  1  ALU zero flag, valid in the BRANCH cycle.
REQ-007 mem_ready  input  1  memory handshake; the access completes on the cycle it is high.
REQ-008 pc_write  output  1  PC register load enable.
REQ-009 ir_write  output  1  instruction register and old_pc load enable.
REQ-010 adr_src  output  1  memory address select: 0 = PC, 1 = result.
REQ-011 mem_write  output  1  memory write strobe.
REQ-012 reg_write  output  1  register-file write enable.
REQ-013 result_src  output  2  result select: 00 = alu_out, 01 = read data, 10 = alu_result.
REQ-014 alu_src_a  output  2  ALU A select: 00 = PC, 01 = old_pc, 10 = rs1, 11 = zero.
REQ-015 alu_src_b  output  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
REQ-016 alu_op  output  2  ALU operation: 00 = add, 01 = sub, 10 = decode funct.
REQ-017 imm_src  output  3  immediate format to the sign extender: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-018 illegal  output  1  one-cycle pulse when an unsupported opcode is decoded.

Function
REQ-019 imm_src SHALL be combinational from op: lw/I-ALU/jalr give 000, sw gives 001, branch gives 010, jal gives 011, lui/auipc give 100, and any other opcode gives 000.
REQ-020 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALR_PC and UPPER.
REQ-021 FETCH SHALL drive adr_src=0, alu_src_a=00, alu_src_b=10 and alu_op=00; ir_write and pc_write SHALL be asserted only in a cycle with mem_ready=1; the state SHALL hold in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-022 DECODE SHALL drive alu_src_a=01, alu_src_b=01 and alu_op=00 (branch/jal target into alu_out), then go to:
- MEMADR for 0000011 or 0100011
- EXECR for 0110011
- EXECI for 0010011
- BRANCH for 1100011
- JAL for 1101111
- JALR for 1100111
- UPPER for 0110111 or 0010111
- FETCH with illegal=1 for any other opcode.
REQ-023 MEMADR SHALL drive rs1+imm (alu_src_a=10, alu_src_b=01, alu_op=00) and go to MEMREAD for a load or MEMWRITE for a store.
REQ-024 MEMREAD SHALL drive adr_src=1 and result_src=00, hold while mem_ready=0, and go to MEMWB when mem_ready=1.
REQ-025 MEMWB SHALL drive result_src=01 and reg_write=1, then go to FETCH.
REQ-026 MEMWRITE SHALL drive adr_src=1, result_src=00 and mem_write=1 continuously until the mem_ready=1 cycle, then go to FETCH.
REQ-027 EXECR SHALL drive alu_src_a=10, alu_src_b=00 and alu_op=10; EXECI SHALL drive alu_src_a=10, alu_src_b=01 and alu_op=10; both SHALL then go to ALUWB.
REQ-028 ALUWB SHALL drive result_src=00 and reg_write=1, then go to FETCH.
REQ-029 BRANCH SHALL drive alu_src_a=10, alu_src_b=00, alu_op=01 and result_src=00, with pc_write = zero XOR funct3[0] (beq/bne), then go to FETCH.
REQ-030 JAL SHALL drive pc_write=1, result_src=00, alu_src_a=01, alu_src_b=10 and alu_op=00, then go to ALUWB.
REQ-031 JALR SHALL compute rs1+imm (as in MEMADR) and go to JALR_PC; JALR_PC SHALL drive pc_write=1, result_src=00, alu_src_a=01, alu_src_b=10 and alu_op=00, then go to ALUWB.
REQ-032 UPPER SHALL drive alu_src_a=11 for lui or 01 for auipc, with alu_src_b=01 and alu_op=00, then go to ALUWB.
REQ-033 All outputs not listed for a state SHALL be 0.
REQ-034 With zero wait states, cycle counts SHALL be: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui/auipc 4.

Reset
REQ-035 While rst_n is low, the state SHALL be FETCH and all registered outputs SHALL be 0.
REQ-036 Assertion of rst_n mid-instruction SHALL abort the instruction immediately, with no mem_write, reg_write or pc_write pulse after assertion.
REQ-037 After release, the first edge SHALL evaluate FETCH.

Structure
REQ-038 A shared package SHALL hold the state enum, the opcode constants, the imm_src, alu_src_a/b, result_src and alu_op encodings, and the IMM_* codes shared with the sign extender.
REQ-039 One sub-module, imm_src_decoder (op -> imm_src, legal), SHALL be used.

Verification
REQ-040 add (op=0110011), mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB; reg_write high only in cycle 4; alu_op=10 in cycle 3.
REQ-041 lw with mem_ready low for 3 FETCH cycles and 2 MEMREAD cycles -> ir_write as a single pulse; 10 cycles total; reg_write with result_src=01.
REQ-042 beq with zero=1 -> pc_write=1 in the BRANCH cycle; bne (funct3=001) with zero=1 -> pc_write=0; imm_src=010 in both cases.
REQ-043 sw, then rst_n pulled low during MEMWRITE with mem_ready=0 -> mem_write drops asynchronously and the state is FETCH after release.
REQ-044 op=1111111 -> illegal=1 for exactly one cycle, return to FETCH, and no reg_write, mem_write or pc_write.
REQ-045 jal then lui -> imm_src 011 then 100; pc_write in the JAL state; UPPER drives alu_src_a=11.
